// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Define UART_ARB_LOCK_EN to let a requester keep the channel across consecutive bytes.
module uart_tx_arb #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [DATA_W-1:0] data0,
   input  logic              lock0,
   output logic              ack0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data1,
   input  logic              lock1,
   output logic              ack1,
   output logic              trmt,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_done,
   output logic              gnt_id,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

   state_t state;
   logic   any_req;
   logic   win;

`ifdef UART_ARB_LOCK_EN
   logic lock_held;
   logic owner_lock;

   assign owner_lock = gnt_id ? lock1 : lock0;
`else
   logic unused_lock;

   assign unused_lock = lock0 ^ lock1;
`endif

   // Round-robin: on contention the requester that did not win last time goes next.
   always_comb begin
      any_req = req0 | req1;
      win     = (req0 && req1) ? ~gnt_id : req1;
`ifdef UART_ARB_LOCK_EN
      if (lock_held && owner_lock) begin
         any_req = gnt_id ? req1 : req0;
         win     = gnt_id;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         trmt    <= 1'b0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         busy    <= 1'b0;
         tx_data <= '0;
         gnt_id  <= 1'b1;
`ifdef UART_ARB_LOCK_EN
         lock_held <= 1'b0;
`endif
      end else begin
         trmt <= 1'b0;
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state   <= LAUNCH;
                  busy    <= 1'b1;
                  trmt    <= 1'b1;
                  ack0    <= ~win;
                  ack1    <= win;
                  gnt_id  <= win;
                  tx_data <= win ? data1 : data0;
`ifdef UART_ARB_LOCK_EN
                  lock_held <= win ? lock1 : lock0;
`endif
               end
`ifdef UART_ARB_LOCK_EN
               else if (!owner_lock) begin
                  lock_held <= 1'b0;
               end
`endif
            end
            LAUNCH: state <= WAIT;
            // tx_done was cleared by our trmt, so any high level here ends the frame.
            WAIT: begin
               if (tx_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random traffic against a transaction-level model.
// Follows UART_ARB_LOCK_EN the same way the design does.
module tb_uart_tx_arb;

`ifdef UART_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       tx_done = 1'b1;
   logic       ack0, ack1, trmt, gnt_id, busy;
   logic [7:0] tx_data;

   uart_tx_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .data0(data0), .lock0(lock0), .ack0(ack0),
      .req1(req1), .data1(data1), .lock1(lock1), .ack1(ack1),
      .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
      .gnt_id(gnt_id), .busy(busy)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   bit         m_last, m_lock;
   logic [7:0] m_txd;
   logic [7:0] q0[$], q1[$], tx_log[$];
   bit         gnt_log[$];
   int         uart_cnt, uart_delay, pushed;
   bit         uart_rand, lock0_drv, lock1_drv;
   logic       p_req0, p_req1, p_lock0, p_lock1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      req0  = (q0.size() != 0);
      data0 = req0 ? q0[0] : 8'h00;
      req1  = (q1.size() != 0);
      data1 = req1 ? q1[0] : 8'h00;
      lock0 = lock0_drv;
      lock1 = lock1_drv;
   endtask

   task automatic model_reset();
      m_last    = 1'b1;
      m_lock    = 1'b0;
      m_txd     = 8'h00;
      uart_cnt  = 0;
      tx_done   = 1'b1;
      lock0_drv = 1'b0;
      lock1_drv = 1'b0;
      q0.delete();
      q1.delete();
      drive();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_trmt", trmt, 0);
      chk("rst_acks", {ack1, ack0}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_gnt_id", gnt_id, 1);
      rst_n = 1'b1;
   endtask

   // One clock: check invariants, score any grant against the model, run the UART model.
   task automatic tick();
      bit         w, locked;
      logic [7:0] d;
      p_req0  = req0;
      p_req1  = req1;
      p_lock0 = lock0;
      p_lock1 = lock1;
      @(posedge clk);
      #1;
      chk("one_ack", ack0 & ack1, 0);
      chk("trmt_ack", trmt, ack0 | ack1);
      if (trmt) begin
         locked = LOCK_EN && m_lock && (m_last ? p_lock1 : p_lock0);
         if (locked) w = m_last;
         else if (p_req0 && p_req1) w = !m_last;
         else w = p_req1;
         chk("req_pending", w ? p_req1 : p_req0, 1);
         chk("ack_winner", {ack1, ack0}, w ? 2'b10 : 2'b01);
         d = 8'h00;
         if (w && q1.size() != 0) d = q1.pop_front();
         else if (!w && q0.size() != 0) d = q0.pop_front();
         chk("tx_data", tx_data, d);
         m_txd  = d;
         m_last = w;
         m_lock = LOCK_EN && (w ? p_lock1 : p_lock0);
         tx_log.push_back(d);
         gnt_log.push_back(w);
         tx_done  = 1'b0;
         uart_cnt = uart_rand ? int'($urandom_range(1, 6)) : uart_delay;
      end else begin
         chk("tx_hold", tx_data, m_txd);
         if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) tx_done = 1'b1;
         end
      end
      chk("gnt_id", gnt_id, m_last);
      drive();
   endtask

   task automatic wait_trmt(input int max);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!trmt && n < max);
      chk("trmt_timeout", trmt, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      uart_delay = 3;
      uart_rand  = 1'b0;
      #1;
      apply_reset();

      // Single byte from requester 0
      q0.push_back(8'hA5);
      drive();
      tick();
      chk("r29_trmt", trmt, 1);
      chk("r29_ack0", ack0, 1);
      chk("r29_tx_data", tx_data, 8'hA5);
      chk("r29_gnt_id", gnt_id, 0);
      chk("r29_busy0", busy, 1);
      tick();
      chk("r29_trmt_1cyc", trmt, 0);
      chk("r29_busy1", busy, 1);
      repeat (2) begin
         tick();
         chk("r29_busy", busy, 1);
      end
      tick();
      chk("r29_idle", busy, 0);

      // Both requesting: strict alternation
      apply_reset();
      uart_delay = 2;
      tx_log.delete();
      gnt_log.delete();
      q0.push_back(8'h11); q0.push_back(8'h11);
      q1.push_back(8'h22); q1.push_back(8'h22);
      drive();
      repeat (4) wait_trmt(40);
      chk("r30_order", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h11221122);
      chk("r30_acks", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b0101);
      repeat (6) tick();

      // Back-to-back latency after tx_done
      apply_reset();
      uart_delay = 5;
      q0.push_back(8'h77);
      q1.push_back(8'h88);
      drive();
      wait_trmt(10);
      chk("r31_ack0", ack0, 1);
      repeat (5) begin
         tick();
         chk("r31_busy", busy, 1);
      end
      tick();
      chk("r31_idle", busy, 0);
      chk("r31_no_trmt", trmt, 0);
      tick();
      chk("r31_trmt", trmt, 1);
      chk("r31_ack1", ack1, 1);
      chk("r31_tx_data", tx_data, 8'h88);
      repeat (8) tick();

      // Asynchronous reset while waiting for the UART
      apply_reset();
      uart_delay = 0;
      q0.push_back(8'h5A);
      drive();
      wait_trmt(10);
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("r32_trmt", trmt, 0);
      chk("r32_busy", busy, 0);
      chk("r32_tx_data", tx_data, 8'h00);
      chk("r32_gnt_id", gnt_id, 1);
      chk("r32_acks", {ack1, ack0}, 0);
      model_reset();
      #1 rst_n = 1'b1;
      q0.push_back(8'h3C);
      drive();
      tick();
      chk("r32_regrant", trmt, 1);
      chk("r32_ack0", ack0, 1);
      chk("r32_data", tx_data, 8'h3C);
      chk("r32_gnt", gnt_id, 0);

      // A request withdrawn before being served is never sent
      repeat (2) tick();
      q1.push_back(8'h99);
      drive();
      repeat (2) tick();
      q1.delete();
      drive();
      tx_done = 1'b1;
      repeat (4) begin
         tick();
         chk("r21_no_tx", trmt, 0);
      end
      chk("r21_idle", busy, 0);

      // Channel lock by requester 0
      apply_reset();
      uart_delay = 2;
      tx_log.delete();
      gnt_log.delete();
      lock0_drv = 1'b1;
      for (int i = 0; i < 4; i++) q0.push_back(8'hA0 + 8'(i));
      q1.push_back(8'hB0); q1.push_back(8'hB1);
      drive();
      repeat (3) wait_trmt(40);
      lock0_drv = 1'b0;
      drive();
      wait_trmt(40);
      chk("r33_grants", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]},
          LOCK_EN ? 4'b0001 : 4'b0101);
      repeat (2) wait_trmt(40);
      chk("r33_drained", q0.size() + q1.size(), 0);
      repeat (8) tick();

      // Random traffic
      apply_reset();
      uart_rand = 1'b1;
      tx_log.delete();
      pushed = 0;
      for (int i = 0; i < 400; i++) begin
         if (q0.size() < 3 && $urandom_range(0, 2) == 0) begin
            q0.push_back(8'($urandom));
            pushed++;
         end
         if (q1.size() < 3 && $urandom_range(0, 2) == 0) begin
            q1.push_back(8'($urandom));
            pushed++;
         end
         drive();
         tick();
      end
      for (int i = 0; i < 300 && (q0.size() + q1.size()) != 0; i++) tick();
      repeat (10) tick();
      chk("rand_drained", q0.size() + q1.size(), 0);
      chk("rand_count", tx_log.size(), pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
